lieat_axi_sram_slave: RTL and testbench
=======================================

Name: lieat_axi_sram_slave

Overview:
- Simulation/FPGA AXI4 responder that terminates the core's io_master_* bus.
- Sits outside the core as the memory-side counterpart of the core's AXI master.
- Serves icache and dcache read bursts and dcache writes from an internal 64-bit word array.
- One transaction in flight at a time, with round-robin arbitration between read and write requests.

Parameters:
- MEM_WORDS, 4096: number of 64-bit words in the array (power of two).
- BASE_ADDR, 32'h8000_0000: byte address mapped to word 0.
- RD_LATENCY, 2: idle cycles between AR handshake and first R beat (0 allowed).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- io_slave_awready  out  1  write address accept
- io_slave_awvalid  in  1  write address valid
- io_slave_awaddr  in  32  write start byte address
- io_slave_awid  in  4  write ID
- io_slave_awlen  in  8  beats minus one
- io_slave_awsize  in  3  bytes per beat = 1<<awsize
- io_slave_awburst  in  2  burst type
- io_slave_wready  out  1  write data accept
- io_slave_wvalid  in  1  write data valid
- io_slave_wdata  in  64  write data
- io_slave_wstrb  in  8  byte enables
- io_slave_wlast  in  1  last write beat
- io_slave_bready  in  1  response accept
- io_slave_bvalid  out  1  response valid
- io_slave_bresp  out  2  OKAY=00, SLVERR=10, DECERR=11
- io_slave_bid  out  4  echo of awid
- io_slave_arready  out  1  read address accept
- io_slave_arvalid  in  1  read address valid
- io_slave_araddr  in  32  read start byte address
- io_slave_arid  in  4  read ID
- io_slave_arlen  in  8  beats minus one
- io_slave_arsize  in  3  bytes per beat
- io_slave_arburst  in  2  burst type
- io_slave_rready  in  1  read data accept
- io_slave_rvalid  out  1  read data valid
- io_slave_rresp  out  2  read response
- io_slave_rdata  out  64  read data
- io_slave_rlast  out  1  last read beat
- io_slave_rid  out  4  echo of arid

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports clock, reset).
- Reset state:
  - State returns to IDLE; prio_write=0; counters cleared.
  - All ready/valid outputs are 0 while reset is high; bresp/rresp/rdata/bid/rid/rlast are 0.
  - Array contents are not reset.
- Reset mid-burst abandons the transaction: no R or B is issued afterwards.
- FSM states: IDLE, RLAT, RDATA, WDATA, BRESP.
- IDLE arbitration:
  - arready = !reset && (!awvalid || !prio_write).
  - awready = !reset && (!arvalid || prio_write).
  - The two readys are never high together when both valids are high.
  - On AR handshake: capture addr/id/len/size/burst, clear beat count, set prio_write=1, go to RLAT (RDATA if RD_LATENCY=0).
  - On AW handshake: capture the same fields, set prio_write=0, go to WDATA.
- RLAT: count RD_LATENCY cycles, then go to RDATA.
- RDATA:
  - rvalid=1; rdata=mem[word index]; rid=captured id; rlast=(beat==len).
  - All outputs are stable until rready.
  - On handshake: advance address, beat++. If the beat was last, go to IDLE in the next cycle; no re-accept in the same cycle.
- WDATA:
  - wready=1.
  - On each wvalid beat: write the strobed bytes of wdata to mem[word index], advance address, beat++.
  - The beat where beat==len ends the phase and moves to BRESP.
- BRESP: bvalid=1 with bid, bresp held until bready; then go to IDLE.
- Address rules:
  - Word index = (addr-BASE_ADDR)>>3.
  - INCR (01) adds 1<<size per beat.
  - FIXED (00) keeps the address.
  - WRAP (10) and reserved (11) are served as INCR but respond SLVERR.
- Range check per beat:
  - Out of range is addr<BASE_ADDR or index>=MEM_WORDS.
  - Read: rdata=0 and rresp=DECERR.
  - Write: beat is dropped and bresp=DECERR; DECERR overrides SLVERR.
- wlast mismatch: wlast on a non-final beat or missing on the final beat gives bresp=SLVERR. Beat count alone terminates the burst.
- Reads always return the full aligned 64-bit word; the master extracts narrow data.
- Throughput: one beat per cycle when the counterpart is always ready.

Test Plan:
- Single write then read: AW 0x8000_0010 len0 size3, wdata 0x1122334455667788, wstrb FF -> B OKAY; AR same address -> after 2 idle cycles, one beat rdata 0x1122334455667788, rlast=1, rresp 00.
- Read burst: preload words 0..3 = 0xA0..0xA3, AR 0x8000_0000 len3 size3 id 5 -> 4 consecutive beats A0..A3, rid 5, rlast only on beat 4; rready low for 3 cycles mid-burst holds rdata.
- Byte strobe: word 0x8000_0008 = 0xFFFF_FFFF_FFFF_FFFF, write wdata 0, wstrb 0x0F -> readback 0xFFFF_FFFF_0000_0000.
- Simultaneous arvalid+awvalid from reset -> read wins first (prio_write=0 after reset); the write is granted next; later conflict alternates.
- Out of range: AR 0x7FFF_FFF8 -> rresp 11, rdata 0; write to BASE+8*MEM_WORDS -> bresp 11, array unchanged.
- Error and reset: len1 write with wlast on beat 0 -> bresp 10. Reset asserted during RDATA beat 2 of 4 -> rvalid drops immediately, IDLE after release, arready=1.

Source files
------------

// File: rtl/lieat_axi_sram_slave.sv
// AXI4 memory-side responder backed by a 64-bit word array.
// One transaction at a time; reads and writes alternate on conflict.
module lieat_axi_sram_slave #(
    parameter int          MEM_WORDS  = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          RD_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_slave_awready,
    input  logic        io_slave_awvalid,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    input  logic [2:0]  io_slave_awsize,
    input  logic [1:0]  io_slave_awburst,
    output logic        io_slave_wready,
    input  logic        io_slave_wvalid,
    input  logic [63:0] io_slave_wdata,
    input  logic [7:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,
    input  logic        io_slave_bready,
    output logic        io_slave_bvalid,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,
    output logic        io_slave_arready,
    input  logic        io_slave_arvalid,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    input  logic [2:0]  io_slave_arsize,
    input  logic [1:0]  io_slave_arburst,
    input  logic        io_slave_rready,
    output logic        io_slave_rvalid,
    output logic [1:0]  io_slave_rresp,
    output logic [63:0] io_slave_rdata,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [7:0] LAT_LAST = 8'(RD_LATENCY > 0 ? RD_LATENCY - 1 : 0);

    typedef enum logic [2:0] {IDLE, RLAT, RDATA, WDATA, BRESP} state_e;

    state_e      state_q, state_d;
    logic        prio_q, prio_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [7:0]  beat_q, beat_d;
    logic [7:0]  lat_q, lat_d;
    logic [1:0]  werr_q, werr_d;

    logic [63:0] mem [MEM_WORDS];

    logic [31:0]   off;
    logic          oor;
    logic [IW-1:0] idx;
    logic [31:0]   step;
    logic          last;
    logic          we;

    assign off  = addr_q - BASE_ADDR;
    assign oor  = (addr_q < BASE_ADDR) || ((off >> (IW + 3)) != 32'd0);
    assign idx  = off[IW+2:3];
    assign step = (burst_q == 2'b00) ? 32'd0 : (32'd1 << size_q);
    assign last = (beat_q == len_q);
    assign we   = (state_q == WDATA) && io_slave_wvalid && !oor;

    // Arbitration: a pending request of the favoured kind blocks the other.
    assign io_slave_arready = !reset && (state_q == IDLE) &&
                              (!io_slave_awvalid || !prio_q);
    assign io_slave_awready = !reset && (state_q == IDLE) &&
                              (!io_slave_arvalid || prio_q);

    assign io_slave_wready = (state_q == WDATA);
    assign io_slave_rvalid = (state_q == RDATA);
    assign io_slave_rdata  = (io_slave_rvalid && !oor) ? mem[idx] : 64'd0;
    assign io_slave_rresp  = !io_slave_rvalid ? 2'b00 :
                             oor              ? 2'b11 :
                             burst_q[1]       ? 2'b10 : 2'b00;
    assign io_slave_rid    = io_slave_rvalid ? id_q : 4'd0;
    assign io_slave_rlast  = io_slave_rvalid && last;
    assign io_slave_bvalid = (state_q == BRESP);
    assign io_slave_bresp  = io_slave_bvalid ? werr_q : 2'b00;
    assign io_slave_bid    = io_slave_bvalid ? id_q : 4'd0;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        werr_d  = werr_q;
        unique case (state_q)
            IDLE: begin
                if (io_slave_arvalid && io_slave_arready) begin
                    addr_d  = io_slave_araddr;
                    id_d    = io_slave_arid;
                    len_d   = io_slave_arlen;
                    size_d  = io_slave_arsize;
                    burst_d = io_slave_arburst;
                    beat_d  = 8'd0;
                    lat_d   = 8'd0;
                    prio_d  = 1'b1;
                    state_d = (RD_LATENCY == 0) ? RDATA : RLAT;
                end else if (io_slave_awvalid && io_slave_awready) begin
                    addr_d  = io_slave_awaddr;
                    id_d    = io_slave_awid;
                    len_d   = io_slave_awlen;
                    size_d  = io_slave_awsize;
                    burst_d = io_slave_awburst;
                    beat_d  = 8'd0;
                    prio_d  = 1'b0;
                    werr_d  = io_slave_awburst[1] ? 2'b10 : 2'b00;
                    state_d = WDATA;
                end
            end
            RLAT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = RDATA;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end
            RDATA: begin
                if (io_slave_rready) begin
                    addr_d = addr_q + step;
                    beat_d = beat_q + 8'd1;
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            WDATA: begin
                if (io_slave_wvalid) begin
                    addr_d = addr_q + step;
                    beat_d = beat_q + 8'd1;
                    // DECERR is sticky and outranks any SLVERR.
                    if (oor) begin
                        werr_d = 2'b11;
                    end else if ((io_slave_wlast != last) && (werr_q != 2'b11)) begin
                        werr_d = 2'b10;
                    end
                    if (last) begin
                        state_d = BRESP;
                    end
                end
            end
            BRESP: begin
                if (io_slave_bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            addr_q  <= 32'd0;
            id_q    <= 4'd0;
            len_q   <= 8'd0;
            size_q  <= 3'd0;
            burst_q <= 2'd0;
            beat_q  <= 8'd0;
            lat_q   <= 8'd0;
            werr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            werr_q  <= werr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 8; b++) begin
                if (io_slave_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= io_slave_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_lieat_axi_sram_slave.sv
// Bench for lieat_axi_sram_slave: directed table, corner sequences,
// and random bursts checked against a word-array reference model.
module tb_lieat_axi_sram_slave;

    localparam int          MEM_WORDS = 4096;
    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam int          RD_LAT    = 2;
    localparam int          TMO       = 200;

    logic        clock, reset;
    logic        awready, awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready, wvalid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bready, bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arready, arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready, rvalid;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    int n_cmp = 0;
    int n_err = 0;
    bit rnd_gaps = 0;
    logic [63:0] model [int];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  resp;
    } vec_t;
    vec_t tbl[$];

    lieat_axi_sram_slave #(
        .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .RD_LATENCY(RD_LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .io_slave_awready(awready), .io_slave_awvalid(awvalid),
        .io_slave_awaddr(awaddr), .io_slave_awid(awid),
        .io_slave_awlen(awlen), .io_slave_awsize(awsize),
        .io_slave_awburst(awburst),
        .io_slave_wready(wready), .io_slave_wvalid(wvalid),
        .io_slave_wdata(wdata), .io_slave_wstrb(wstrb),
        .io_slave_wlast(wlast),
        .io_slave_bready(bready), .io_slave_bvalid(bvalid),
        .io_slave_bresp(bresp), .io_slave_bid(bid),
        .io_slave_arready(arready), .io_slave_arvalid(arvalid),
        .io_slave_araddr(araddr), .io_slave_arid(arid),
        .io_slave_arlen(arlen), .io_slave_arsize(arsize),
        .io_slave_arburst(arburst),
        .io_slave_rready(rready), .io_slave_rvalid(rvalid),
        .io_slave_rresp(rresp), .io_slave_rdata(rdata),
        .io_slave_rlast(rlast), .io_slave_rid(rid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: handshake timeout after %0d cycles", name, TMO);
    endtask

    function automatic bit out_of_range(input logic [31:0] a);
        return (a < BASE) || ({32'd0, a} >= ({32'd0, BASE} + 64'(8 * MEM_WORDS)));
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int sz,
                                              input logic [1:0] bu, input int i);
        return (bu == 2'b00) ? a : a + 32'(i << sz);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic set_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
        araddr = a; arid = id; arlen = len; arsize = sz; arburst = bu;
    endtask

    task automatic set_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
        awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bu;
    endtask

    task automatic ar_phase(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu);
        bit hs;
        set_ar(a, id, len, sz, bu);
        arvalid = 1'b1;
        for (int c = 0; c <= TMO; c++) begin
            @(negedge clock);
            hs = arready;
            @(posedge clock); #1;
            if (hs) break;
            if (c == TMO) tmo("ar_handshake");
        end
        arvalid = 1'b0;
    endtask

    task automatic aw_phase(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] bu);
        bit hs;
        set_aw(a, id, len, sz, bu);
        awvalid = 1'b1;
        for (int c = 0; c <= TMO; c++) begin
            @(negedge clock);
            hs = awready;
            @(posedge clock); #1;
            if (hs) break;
            if (c == TMO) tmo("aw_handshake");
        end
        awvalid = 1'b0;
    endtask

    task automatic r_phase(input int len_total, input int ntake, input logic [3:0] id,
                           input logic [63:0] ed[$], input logic [1:0] er[$],
                           input int stall_at, output int idle);
        int beat, stall, c;
        bit seen;
        beat = 0; stall = 0; c = 0; seen = 0; idle = 0;
        rready = 1'b1;
        while (beat < ntake) begin
            @(negedge clock);
            if (seen) chk("r_stream_valid", 64'(rvalid), 64'd1);
            if (rvalid) begin
                seen = 1;
                if (rready) begin
                    chk("r_data", rdata, ed[beat]);
                    chk("r_resp", 64'(rresp), 64'(er[beat]));
                    chk("r_last", 64'(rlast), 64'(beat == len_total - 1));
                    chk("r_id", 64'(rid), 64'(id));
                    beat++;
                    if (beat == stall_at) stall = 3;
                end else begin
                    chk("r_hold_data", rdata, ed[beat]);
                end
            end else if (!seen) begin
                idle++;
            end
            @(posedge clock); #1;
            if (stall > 0) begin
                rready = 1'b0;
                stall--;
            end else begin
                rready = rnd_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (++c > TMO) begin
                tmo("r_beats");
                break;
            end
        end
        rready = 1'b0;
    endtask

    task automatic w_phase(input int n, input logic [63:0] wd[$], input logic [7:0] ws[$],
                           input int bad);
        bit hs;
        for (int i = 0; i < n; i++) begin
            wdata = wd[i];
            wstrb = ws[i];
            wlast = (i == n - 1) ^ (i == bad);
            if (rnd_gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge clock); #1;
            end
            wvalid = 1'b1;
            for (int c = 0; c <= TMO; c++) begin
                @(negedge clock);
                hs = wready;
                @(posedge clock); #1;
                if (hs) break;
                if (c == TMO) tmo("w_handshake");
            end
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic b_phase(output logic [1:0] r, output logic [3:0] id);
        bit hs;
        r = 2'bxx;
        id = 4'bxxxx;
        bready = rnd_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 0; c <= TMO; c++) begin
            @(negedge clock);
            hs = bvalid && bready;
            if (hs) begin
                r = bresp;
                id = bid;
            end
            @(posedge clock); #1;
            if (hs) break;
            bready = rnd_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (c == TMO) tmo("b_handshake");
        end
        bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] id, input int len,
                            input int sz, input logic [1:0] bu, input logic [63:0] wd[$],
                            input logic [7:0] ws[$], input int bad, input logic [1:0] exp);
        logic [1:0] r;
        logic [3:0] i;
        aw_phase(a, id, 8'(len), 3'(sz), bu);
        w_phase(len + 1, wd, ws, bad);
        b_phase(r, i);
        chk("b_resp", 64'(r), 64'(exp));
        chk("b_id", 64'(i), 64'(id));
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] id, input int len,
                           input int sz, input logic [1:0] bu, input logic [63:0] ed[$],
                           input logic [1:0] er[$], input int stall_at);
        int idle;
        ar_phase(a, id, 8'(len), 3'(sz), bu);
        r_phase(len + 1, len + 1, id, ed, er, stall_at, idle);
        chk("r_latency", 64'(idle), 64'(RD_LAT));
    endtask

    task automatic pulse_reset();
        @(posedge clock); #2;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    function automatic void add(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                                input logic [1:0] bu, input logic [63:0] d,
                                input logic [7:0] s, input logic [1:0] rsp);
        vec_t v;
        v.wr = wr; v.addr = a; v.size = sz; v.burst = bu;
        v.data = d; v.strb = s; v.resp = rsp;
        tbl.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] qd[$];
        logic [7:0]  qs[$];
        logic [1:0]  qr[$];
        logic [1:0]  r;
        logic [3:0]  i4;
        int          idle;
        logic [31:0] top;

        top = BASE + 32'(8 * MEM_WORDS);
        reset = 1'b1;
        awvalid = 1'b1; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
        wvalid = 1'b1; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b1;
        arvalid = 1'b1; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
        rready = 1'b1;

        // Outputs must be quiet while reset is held, even with requests pending.
        repeat (2) @(negedge clock);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_resp", {58'd0, rresp, bresp, rlast}, 64'd0);
        chk("rst_ids", {56'd0, rid, bid}, 64'd0);
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        @(posedge clock); #1 reset = 1'b0;

        add(1, BASE + 32'h10, 3, 2'b01, 64'h1122334455667788, 8'hFF, 2'b00);
        add(0, BASE + 32'h10, 3, 2'b01, 64'h1122334455667788, 8'h00, 2'b00);
        add(0, BASE + 32'h13, 0, 2'b01, 64'h1122334455667788, 8'h00, 2'b00);
        add(1, BASE + 32'h08, 3, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00);
        add(1, BASE + 32'h08, 3, 2'b01, 64'h0, 8'h0F, 2'b00);
        add(0, BASE + 32'h08, 3, 2'b01, 64'hFFFF_FFFF_0000_0000, 8'h00, 2'b00);
        add(1, BASE, 3, 2'b01, 64'hA0, 8'hFF, 2'b00);
        add(1, top, 3, 2'b01, 64'hDEAD, 8'hFF, 2'b11);
        add(0, BASE, 3, 2'b01, 64'hA0, 8'h00, 2'b00);
        add(0, 32'h7FFF_FFF8, 3, 2'b01, 64'h0, 8'h00, 2'b11);
        add(0, top, 3, 2'b01, 64'h0, 8'h00, 2'b11);
        add(1, top - 32'd8, 3, 2'b01, 64'h0BAD_F00D_CAFE_BEEF, 8'hFF, 2'b00);
        add(0, top - 32'd8, 3, 2'b01, 64'h0BAD_F00D_CAFE_BEEF, 8'h00, 2'b00);
        add(1, BASE + 32'h20, 3, 2'b10, 64'h55, 8'hFF, 2'b10);
        add(0, BASE + 32'h20, 3, 2'b10, 64'h55, 8'h00, 2'b10);
        add(0, BASE + 32'h20, 3, 2'b11, 64'h55, 8'h00, 2'b10);
        add(0, BASE + 32'h20, 3, 2'b00, 64'h55, 8'h00, 2'b00);

        foreach (tbl[k]) begin
            qd = {tbl[k].data};
            qs = {tbl[k].strb};
            qr = {tbl[k].resp};
            if (tbl[k].wr)
                do_write(tbl[k].addr, 4'(k), 0, int'(tbl[k].size), tbl[k].burst,
                         qd, qs, -1, tbl[k].resp);
            else
                do_read(tbl[k].addr, 4'(k), 0, int'(tbl[k].size), tbl[k].burst,
                        qd, qr, -1);
        end

        // Arbitration from reset: read first, then write, then read again.
        pulse_reset();
        set_ar(BASE + 32'h10, 4'h1, 8'd0, 3'd3, 2'b01);
        set_aw(BASE + 32'h30, 4'h2, 8'd0, 3'd3, 2'b01);
        arvalid = 1'b1;
        awvalid = 1'b1;
        @(negedge clock);
        chk("arb1_arready", 64'(arready), 64'd1);
        chk("arb1_awready", 64'(awready), 64'd0);
        @(posedge clock); #1 arvalid = 1'b0;
        qd = {64'h1122334455667788};
        qr = {2'b00};
        r_phase(1, 1, 4'h1, qd, qr, -1, idle);
        set_ar(BASE + 32'h10, 4'h3, 8'd0, 3'd3, 2'b01);
        arvalid = 1'b1;
        @(negedge clock);
        chk("arb2_awready", 64'(awready), 64'd1);
        chk("arb2_arready", 64'(arready), 64'd0);
        @(posedge clock); #1 awvalid = 1'b0;
        qd = {64'h3030};
        qs = {8'hFF};
        w_phase(1, qd, qs, -1);
        b_phase(r, i4);
        chk("arb2_bresp", 64'(r), 64'd0);
        chk("arb2_bid", 64'(i4), 64'd2);
        set_aw(BASE + 32'h38, 4'h4, 8'd0, 3'd3, 2'b01);
        awvalid = 1'b1;
        @(negedge clock);
        chk("arb3_arready", 64'(arready), 64'd1);
        chk("arb3_awready", 64'(awready), 64'd0);
        @(posedge clock); #1 arvalid = 1'b0;
        qd = {64'h1122334455667788};
        r_phase(1, 1, 4'h3, qd, qr, -1, idle);
        qd = {64'h3838};
        aw_phase(BASE + 32'h38, 4'h4, 8'd0, 3'd3, 2'b01);
        w_phase(1, qd, qs, -1);
        b_phase(r, i4);
        chk("arb4_bresp", 64'(r), 64'd0);
        qd = {64'h3030};
        do_read(BASE + 32'h30, 4'h6, 0, 3, 2'b01, qd, qr, -1);

        // Bursts: 4-beat write, 4-beat read with a 3-cycle stall, FIXED, narrow.
        qd = {64'hA0, 64'hA1, 64'hA2, 64'hA3};
        qs = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_write(BASE, 4'h3, 3, 3, 2'b01, qd, qs, -1, 2'b00);
        qr = {2'b00, 2'b00, 2'b00, 2'b00};
        do_read(BASE, 4'h5, 3, 3, 2'b01, qd, qr, 2);
        qd = {64'hA1, 64'hA1, 64'hA1};
        qr = {2'b00, 2'b00, 2'b00};
        do_read(BASE + 32'h8, 4'h7, 2, 3, 2'b00, qd, qr, -1);
        qd = {64'hA0, 64'hA0, 64'hA1, 64'hA1};
        qr = {2'b00, 2'b00, 2'b00, 2'b00};
        do_read(BASE, 4'h8, 3, 2, 2'b01, qd, qr, -1);

        // Write error corners.
        qd = {64'h11, 64'h22};
        qs = {8'hFF, 8'hFF};
        do_write(BASE + 32'h40, 4'h9, 1, 3, 2'b01, qd, qs, 0, 2'b10);
        qd = {64'h33};
        qs = {8'hFF};
        do_write(BASE + 32'h48, 4'hA, 0, 3, 2'b01, qd, qs, 0, 2'b10);
        qd = {64'h44, 64'h55};
        qs = {8'hFF, 8'hFF};
        do_write(top - 32'd8, 4'hB, 1, 3, 2'b10, qd, qs, -1, 2'b11);

        // Random traffic against the reference model.
        rnd_gaps = 1;
        for (int w = 0; w < 26; w++) begin
            int wi;
            logic [63:0] d;
            wi = (w < 24) ? w : MEM_WORDS - 26 + w;
            d = {$urandom(), $urandom()};
            qd = {d};
            qs = {8'hFF};
            do_write(BASE + 32'(8 * wi), 4'(w), 0, 3, 2'b01, qd, qs, -1, 2'b00);
            model[wi] = d;
        end
        for (int t = 0; t < 40; t++) begin
            int sz, len, bad, wbase, off;
            logic [1:0]  bu;
            logic [31:0] a, ba;
            logic [3:0]  id;
            bit dec;
            sz = $urandom_range(0, 3);
            len = $urandom_range(0, 3);
            bu = 2'($urandom_range(0, 3));
            wbase = ($urandom_range(0, 7) == 0) ? MEM_WORDS - 2 : $urandom_range(0, 15);
            off = $urandom_range(0, 7) & ~((1 << sz) - 1);
            a = BASE + 32'(8 * wbase + off);
            id = 4'($urandom_range(0, 15));
            qd = {};
            qs = {};
            qr = {};
            if ($urandom_range(0, 1) == 1) begin
                bad = ($urandom_range(0, 5) == 0) ? 0 : -1;
                dec = 0;
                for (int i = 0; i <= len; i++) begin
                    logic [63:0] d;
                    logic [7:0]  s;
                    int wi;
                    d = {$urandom(), $urandom()};
                    s = 8'($urandom());
                    qd.push_back(d);
                    qs.push_back(s);
                    ba = beat_addr(a, sz, bu, i);
                    if (out_of_range(ba)) begin
                        dec = 1;
                    end else begin
                        wi = int'((ba - BASE) >> 3);
                        model[wi] = merge(model[wi], d, s);
                    end
                end
                do_write(a, id, len, sz, bu, qd, qs, bad,
                         dec ? 2'b11 : ((bu[1] || bad >= 0) ? 2'b10 : 2'b00));
            end else begin
                for (int i = 0; i <= len; i++) begin
                    ba = beat_addr(a, sz, bu, i);
                    if (out_of_range(ba)) begin
                        qd.push_back(64'd0);
                        qr.push_back(2'b11);
                    end else begin
                        qd.push_back(model[int'((ba - BASE) >> 3)]);
                        qr.push_back(bu[1] ? 2'b10 : 2'b00);
                    end
                end
                do_read(a, id, len, sz, bu, qd, qr, -1);
            end
        end
        rnd_gaps = 0;

        // Reset while beat 2 of 4 is being presented.
        qd = {model[0], model[1], model[2], model[3]};
        qr = {2'b00, 2'b00, 2'b00, 2'b00};
        ar_phase(BASE, 4'h2, 8'd3, 3'd3, 2'b01);
        r_phase(4, 2, 4'h2, qd, qr, -1, idle);
        @(negedge clock);
        chk("rstmid_pre_rvalid", 64'(rvalid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_rvalid", 64'(rvalid), 64'd0);
        chk("rstmid_arready", 64'(arready), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        rready = 1'b1;
        repeat (4) begin
            @(negedge clock);
            chk("rstmid_post_rvalid", 64'(rvalid), 64'd0);
            chk("rstmid_post_arready", 64'(arready), 64'd1);
        end
        @(posedge clock); #1 rready = 1'b0;
        qd = {model[0]};
        qr = {2'b00};
        do_read(BASE, 4'hC, 0, 3, 2'b01, qd, qr, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
